// File: rtl/mips_mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control path:
// FSM states, opcode/funct values, ALU codes and datapath select constants.
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_IMMWB   = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12,
        S_LIMMEX  = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] AOP_ADD   = 2'b00;
    localparam logic [1:0] AOP_SUB   = 2'b01;
    localparam logic [1:0] AOP_FUNCT = 2'b10;
    localparam logic [1:0] AOP_LIMM  = 2'b11;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_mc_alu_decoder.sv
// Combinational ALU control decode: fixed add/sub, R-type funct lookup,
// or and/or selection for the zero-extended logic immediates.
module mips_mc_alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [5:0] funct_i,
    input  logic [5:0] op_i,
    output logic [2:0] alu_control_o,
    output logic       funct_illegal_o
);

    always_comb begin
        alu_control_o   = ALU_ADD;
        funct_illegal_o = 1'b0;
        case (alu_op_i)
            AOP_SUB: alu_control_o = ALU_SUB;
            AOP_FUNCT: begin
                case (funct_i)
                    F_ADD:   alu_control_o = ALU_ADD;
                    F_SUB:   alu_control_o = ALU_SUB;
                    F_AND:   alu_control_o = ALU_AND;
                    F_OR:    alu_control_o = ALU_OR;
                    F_SLT:   alu_control_o = ALU_SLT;
                    default: funct_illegal_o = 1'b1;  // ALU falls back to add
                endcase
            end
            AOP_LIMM: alu_control_o = (op_i == OP_ORI) ? ALU_OR : ALU_AND;
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory with a ready handshake and drives the datapath selects.
module mips_multicycle_controller
    import mips_mc_pkg::*;
#(
    parameter int ALU_CTRL_W       = 3,
    parameter bit ENABLE_BNE       = 1'b1,
    parameter bit ENABLE_LOGIC_IMM = 1'b1,
    parameter bit MEM_WAIT         = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            op_i,
    input  logic [5:0]            funct_i,
    input  logic                  zero_i,
    input  logic                  mem_ready_i,
    output logic                  iord_o,
    output logic                  mem_read_o,
    output logic                  mem_write_o,
    output logic                  ir_write_o,
    output logic                  reg_dst_o,
    output logic                  mem_to_reg_o,
    output logic                  reg_write_o,
    output logic                  alu_src_a_o,
    output logic [1:0]            alu_src_b_o,
    output logic                  imm_ext_o,
    output logic [ALU_CTRL_W-1:0] alu_control_o,
    output logic [1:0]            pc_src_o,
    output logic                  pc_en_o,
    output logic                  illegal_o,
    output logic [3:0]            state_o
);

    state_t     state_q, state_d;
    logic       rdy;
    logic       mem_read, mem_write, ir_write, reg_write;
    logic       pc_write, branch_eq, branch_ne;
    logic       op_illegal, chk_funct, funct_illegal, alu_use;
    logic [1:0] alu_op;
    logic [2:0] alu_ctrl;

    assign rdy = MEM_WAIT ? mem_ready_i : 1'b1;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    mips_mc_alu_decoder u_alu_dec (
        .alu_op_i        (alu_op),
        .funct_i         (funct_i),
        .op_i            (op_i),
        .alu_control_o   (alu_ctrl),
        .funct_illegal_o (funct_illegal)
    );

    always_comb begin
        state_d      = state_q;
        iord_o       = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        reg_write    = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = SRCB_REG;
        imm_ext_o    = 1'b0;
        pc_src_o     = PC_ALU;
        pc_write     = 1'b0;
        branch_eq    = 1'b0;
        branch_ne    = 1'b0;
        op_illegal   = 1'b0;
        chk_funct    = 1'b0;
        alu_use      = 1'b0;
        alu_op       = AOP_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read    = 1'b1;
                alu_src_b_o = SRCB_FOUR;
                alu_use     = 1'b1;
                ir_write    = rdy;
                pc_write    = rdy;
                if (rdy) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b_o = SRCB_IMMSH;
                alu_use     = 1'b1;
                state_d     = S_FETCH;
                case (op_i)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    OP_BNE: begin
                        if (ENABLE_BNE) state_d = S_BNEEX;
                        else            op_illegal = 1'b1;
                    end
                    OP_ANDI, OP_ORI: begin
                        if (ENABLE_LOGIC_IMM) state_d = S_LIMMEX;
                        else                  op_illegal = 1'b1;
                    end
                    default: op_illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_use     = 1'b1;
                state_d     = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord_o   = 1'b1;
                mem_read = 1'b1;
                if (rdy) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write    = 1'b1;
                mem_to_reg_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWR: begin
                iord_o    = 1'b1;
                mem_write = 1'b1;
                if (rdy) state_d = S_FETCH;
            end
            S_RTYPEEX: begin
                alu_src_a_o = 1'b1;
                alu_use     = 1'b1;
                alu_op      = AOP_FUNCT;
                chk_funct   = 1'b1;
                state_d     = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                reg_write = 1'b1;
                reg_dst_o = 1'b1;
                state_d   = S_FETCH;
            end
            S_BEQEX, S_BNEEX: begin
                alu_src_a_o = 1'b1;
                alu_use     = 1'b1;
                alu_op      = AOP_SUB;
                pc_src_o    = PC_ALUOUT;
                branch_eq   = (state_q == S_BEQEX);
                branch_ne   = (state_q == S_BNEEX);
                state_d     = S_FETCH;
            end
            S_ADDIEX, S_LIMMEX: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = SRCB_IMM;
                alu_use     = 1'b1;
                imm_ext_o   = (state_q == S_LIMMEX);
                alu_op      = (state_q == S_LIMMEX) ? AOP_LIMM : AOP_ADD;
                state_d     = S_IMMWB;
            end
            S_IMMWB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_JEX: begin
                pc_src_o = PC_JUMP;
                pc_write = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are masked combinationally so a reset aborts the cycle it lands in.
    assign mem_read_o    = mem_read  & ~reset;
    assign mem_write_o   = mem_write & ~reset;
    assign ir_write_o    = ir_write  & ~reset;
    assign reg_write_o   = reg_write & ~reset;
    assign pc_en_o       = ~reset & (pc_write | (branch_eq & zero_i) | (branch_ne & ~zero_i));
    assign illegal_o     = ~reset & (op_illegal | (chk_funct & funct_illegal));
    assign alu_control_o = alu_use ? ALU_CTRL_W'(alu_ctrl) : '0;
    assign state_o       = reset ? 4'd0 : 4'(state_q);

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
Multicycle successor to the single-cycle control path: one FSM sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK over several cycles for a shared instruction/data memory. It drives the multicycle datapath's mux selects and write enables, plus the combined PC enable. It adds a memory-ready handshake for multi-cycle memory, optional BNE, and optional ANDI/ORI (zero-extended immediate).

Parameters:
ALU_CTRL_W, 3, width of alu_control_o
ENABLE_BNE, 1, 1 = decode bne (000101); 0 = treat it as illegal
ENABLE_LOGIC_IMM, 1, 1 = decode andi (001100) and ori (001101); 0 = treat them as illegal
MEM_WAIT, 1, 1 = honour mem_ready_i; 0 = memory is assumed single-cycle and mem_ready_i is ignored

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
op_i  in  6  instr[31:26] from the instruction register
funct_i  in  6  instr[5:0]
zero_i  in  1  ALU zero flag (combinational, same cycle)
mem_ready_i  in  1  memory access completes this cycle
iord_o  out  1  0 = address from PC, 1 = address from ALUOut
mem_read_o  out  1  memory read strobe
mem_write_o  out  1  memory write strobe
ir_write_o  out  1  instruction register load
reg_dst_o  out  1  1 = rd, 0 = rt
mem_to_reg_o  out  1  1 = writeback from the data register
reg_write_o  out  1  register file write enable
alu_src_a_o  out  1  0 = PC, 1 = register A
alu_src_b_o  out  2  00 = B, 01 = constant 4, 10 = extended immediate, 11 = extended immediate << 2
imm_ext_o  out  1  0 = sign-extend, 1 = zero-extend
alu_control_o  out  ALU_CTRL_W  010 add, 110 sub, 000 and, 001 or, 111 slt
pc_src_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
pc_en_o  out  1  PC load enable
illegal_o  out  1  one-cycle flag for an illegal opcode or funct
state_o  out  4  current state encoding (debug)

Behaviour:
- State encoding (4-bit): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, IMMWB 10, JEX 11, BNEEX 12, LIMMEX 13. Encodings 14 and 15 return to FETCH on the next edge.
- Outputs are Moore-style decodes of the state. Exceptions: pc_en_o uses zero_i and mem_ready_i; the FETCH enables use mem_ready_i; illegal_o uses op_i and funct_i.
- Every output not listed for a state is 0.
- Per-state outputs:
  - FETCH: mem_read=1, iord=0, srcA=0, srcB=01, add, pc_src=00. ir_write and pc_write = rdy.
  - DECODE: srcA=0, srcB=11, add (precomputes the branch target).
  - MEMADR: srcA=1, srcB=10, add.
  - MEMRD: iord=1, mem_read=1.
  - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0.
  - MEMWR: iord=1, mem_write=1.
  - RTYPEEX: srcA=1, srcB=00, ALU op from funct: 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - RTYPEWB: reg_write=1, reg_dst=1.
  - BEQEX: srcA=1, srcB=00, sub, pc_src=01, branch_eq=1.
  - BNEEX: same as BEQEX but with branch_ne=1.
  - ADDIEX: srcA=1, srcB=10, add, imm_ext=0.
  - LIMMEX: srcA=1, srcB=10, imm_ext=1; and for andi, or for ori.
  - IMMWB: reg_write=1, reg_dst=0, mem_to_reg=0.
  - JEX: pc_src=10, pc_write=1.
- Definitions:
  - rdy = mem_ready_i when MEM_WAIT=1, otherwise 1.
  - pc_en_o = pc_write | (branch_eq & zero_i) | (branch_ne & ~zero_i).
- Transitions:
  - FETCH→DECODE when rdy; otherwise stay in FETCH with all outputs held.
  - DECODE dispatch on op_i:
    - lw or sw → MEMADR
    - R-type → RTYPEEX
    - beq → BEQEX
    - bne → BNEEX (ENABLE_BNE only)
    - addi → ADDIEX
    - andi or ori → LIMMEX (ENABLE_LOGIC_IMM only)
    - j → JEX
    - anything else → FETCH, with illegal_o=1 during DECODE.
  - MEMADR→MEMRD for lw, →MEMWR for sw.
  - MEMRD→MEMWB when rdy; otherwise stay in MEMRD. MEMWR→FETCH when rdy; otherwise stay in MEMWR.
  - MEMWB, RTYPEWB, IMMWB, BEQEX, BNEEX and JEX each go to FETCH.
  - RTYPEEX→RTYPEWB; ADDIEX→IMMWB; LIMMEX→IMMWB.
- Unknown funct in RTYPEEX: ALU does add, illegal_o=1 for that cycle, and the sequence still goes through RTYPEWB. The write happens; software is responsible.
- Reset: the state register is forced to FETCH at the edge. While reset is high, ir_write, pc_en, reg_write, mem_write and mem_read are forced to 0, illegal_o=0, and state_o reads 0. Reset asserted mid-instruction (including during MEMWR wait) aborts the instruction; no write strobe is asserted in that cycle.
- CPI: lw 5, sw 4, R-type 4, addi/andi/ori 4, beq/bne 3, j 3, plus one cycle for each cycle of memory wait.

Decomposition:
- Package mips_mc_pkg holds:
  - the state_t enum with the encodings above
  - opcode and funct localparams
  - ALU control codes
  - the alu_src_b and pc_src select constants.
- One sub-module, mips_mc_alu_decoder (combinational):
  - inputs: alu_op[1:0] (00 add, 01 sub, 10 funct, 11 logic-imm by op), funct, op
  - outputs: alu_control and the funct-illegal flag.
- The FSM and output decode live in mips_multicycle_controller.

Test Plan:
- lw (op 100011) with mem_ready_i tied 1: state_o sequence 0,1,2,3,4,0. ir_write and pc_en high only in the FETCH cycle; reg_write and mem_to_reg high in state 4.
- sw with mem_ready_i low for 3 cycles in MEMWR: state_o stays 5 for 4 cycles with mem_write_o=1 throughout, then returns to 0. reg_write never asserts.
- beq with zero_i=1: pc_en_o=1 and pc_src_o=01 in state 8. Same instruction with zero_i=0: pc_en_o=0. bne with zero_i=0: pc_en_o=1 in state 12.
- ori (op 001101) with ENABLE_LOGIC_IMM=1: state 13 gives imm_ext_o=1 and alu_control_o=001, then state 10 gives reg_write=1. With ENABLE_LOGIC_IMM=0: DECODE pulses illegal_o and the FSM returns to FETCH.
- R-type funct 101010: alu_control_o=111 in state 6, then reg_dst=1 and reg_write=1 in state 7. funct 111111: illegal_o=1 in state 6.
- Reset asserted in MEMRD while mem_ready_i=0: next state_o=0. All write enables stay 0 during reset, and fetch resumes the cycle after reset deasserts.
